// File: rtl/bus_reader_if.sv
// Bus-side capture and consumer handshake signals of a bus_reader.
// The master is the bus/consumer side; the slave is the reader FIFO.
interface bus_reader_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
);
  logic [WIDTH-1:0] bus;
  logic             load;
  logic             clear;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output bus, load, clear, out_ready,
    input  out_data, out_valid, full, empty, count, overflow
  );

  modport slave (
    input  bus, load, clear, out_ready,
    output out_data, out_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/bus_reader.sv
// Captures the shared tristate bus on load strobes into a small first-word
// fall-through FIFO and presents the words through a valid/ready handshake.
module bus_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          clock,
  input  logic          reset,
  bus_reader_if.slave   rd
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             primed;

  logic full_c;
  logic empty_c;
  logic pop;
  logic push;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign pop     = !empty_c && rd.out_ready;
  // A full FIFO still accepts a load when the head leaves in the same cycle.
  assign push    = rd.load && (!full_c || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      primed  <= 1'b0;
    end else if (rd.clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        primed <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (rd.load && !push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !rd.clear) begin
      mem[wr_ptr] <= rd.bus;
    end
  end

  // Until the first capture after reset the storage is undefined, so show zero.
  assign rd.out_data  = primed ? mem[rd_ptr] : '0;
  assign rd.out_valid = !empty_c;
  assign rd.full      = full_c;
  assign rd.empty     = empty_c;
  assign rd.count     = count_q;
  assign rd.overflow  = ovf_q;

endmodule

// File: tb/tb_bus_reader.sv
// Directed testbench for bus_reader: reset, capture, overflow, wrap, backpressure,
// clear priority and asynchronous reset.
module tb_bus_reader;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  bus_reader_if #(.WIDTH(32), .CNT_W(3)) bif ();

  bus_reader #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .rd    (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bif.load = 1'b0; bif.clear = 1'b0; bif.out_ready = 1'b0; bif.bus = '0;
  endtask

  task automatic flush();
    bif.clear = 1'b1; step(); bif.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle();
    step(); step();
    vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bif.out_valid); end
    vectors++; if (bif.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", bif.empty); end
    vectors++; if (bif.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", bif.full); end
    vectors++; if (bif.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", bif.overflow); end
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bif.count); end
    vectors++; if (bif.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bif.out_data); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    bif.bus = 32'h12345678; bif.load = 1'b1;
    step();
    bif.load = 1'b0;
    vectors++; if (bif.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bif.out_valid); end
    vectors++; if (bif.out_data !== 32'h12345678) begin miscompares++; $display("FAIL single_data: got %h want 12345678", bif.out_data); end
    vectors++; if (bif.count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", bif.count); end
    vectors++; if (bif.empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b want 0", bif.empty); end
    bif.out_ready = 1'b1;
    step();
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d want 0", bif.count); end
    vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid: got %b want 0", bif.out_valid); end
    // ready while empty must not move anything
    step();
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL empty_ready_count: got %0d want 0", bif.count); end
    bif.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      bif.bus = 32'hA0 + i; bif.load = 1'b1;
      step();
    end
    bif.load = 1'b0;
    vectors++; if (bif.count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", bif.count); end
    vectors++; if (bif.full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", bif.full); end
    vectors++; if (bif.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", bif.overflow); end
    bif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bif.out_data !== 32'hA0 + i) begin miscompares++; $display("FAIL ovf_order%0d: got %h want %h", i, bif.out_data, 32'hA0 + i); end
      step();
    end
    bif.out_ready = 1'b0;
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL ovf_drain_count: got %0d want 0 (A4 must be dropped)", bif.count); end
    vectors++; if (bif.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", bif.overflow); end
  endtask

  task automatic test_full_push_pop();
    flush();
    vectors++; if (bif.overflow !== 1'b0) begin miscompares++; $display("FAIL clear_ovf: got %b want 0", bif.overflow); end
    for (int i = 0; i < 4; i++) begin
      bif.bus = 32'hB0 + i; bif.load = 1'b1;
      step();
    end
    bif.bus = 32'hB4; bif.out_ready = 1'b1;
    step();
    bif.load = 1'b0;
    vectors++; if (bif.count !== 3'd4) begin miscompares++; $display("FAIL fpp_count: got %0d want 4", bif.count); end
    vectors++; if (bif.overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow: got %b want 0", bif.overflow); end
    for (int i = 1; i < 5; i++) begin
      vectors++; if (bif.out_data !== 32'hB0 + i) begin miscompares++; $display("FAIL fpp_order%0d: got %h want %h", i, bif.out_data, 32'hB0 + i); end
      step();
    end
    bif.out_ready = 1'b0;
    vectors++; if (bif.empty !== 1'b1) begin miscompares++; $display("FAIL fpp_empty: got %b want 1", bif.empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      bif.bus = 32'h100 + i; bif.load = 1'b1; bif.out_ready = 1'b1;
      step();
      vectors++; if (bif.count !== 3'd1) begin miscompares++; $display("FAIL wrap_count%0d: got %0d want 1", i, bif.count); end
      vectors++; if (bif.out_data !== 32'h100 + i) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", i, bif.out_data, 32'h100 + i); end
    end
    bif.load = 1'b0;
    step();
    bif.out_ready = 1'b0;
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL wrap_end_count: got %0d want 0", bif.count); end
    vectors++; if (bif.overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_overflow: got %b want 0", bif.overflow); end
  endtask

  task automatic test_back_to_back();
    bif.bus = 32'hC0; bif.load = 1'b1; step();
    bif.bus = 32'hC1; step();
    bif.bus = 32'hC2; step();
    bif.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bif.out_data !== 32'hC0) begin miscompares++; $display("FAIL bp_hold%0d: got %h want c0", i, bif.out_data); end
      if (i < 2) step();
    end
    vectors++; if (bif.count !== 3'd3) begin miscompares++; $display("FAIL bp_count: got %0d want 3", bif.count); end
  endtask

  task automatic test_clear_reset();
    flush();
    for (int i = 0; i < 5; i++) begin
      bif.bus = 32'hD0 + i; bif.load = 1'b1; step();
    end
    bif.load = 1'b0; bif.out_ready = 1'b1; step(); bif.out_ready = 1'b0;
    vectors++; if (bif.count !== 3'd3 || bif.overflow !== 1'b1) begin miscompares++; $display("FAIL cr_setup: got count %0d ovf %b want 3 1", bif.count, bif.overflow); end
    bif.clear = 1'b1; bif.load = 1'b1; bif.out_ready = 1'b1; bif.bus = 32'hDEAD;
    step();
    bif.clear = 1'b0; bif.load = 1'b0; bif.out_ready = 1'b0;
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL clr_count: got %0d want 0", bif.count); end
    vectors++; if (bif.empty !== 1'b1) begin miscompares++; $display("FAIL clr_empty: got %b want 1", bif.empty); end
    vectors++; if (bif.overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow: got %b want 0", bif.overflow); end
    bif.bus = 32'hD5; bif.load = 1'b1; step();
    bif.bus = 32'hD6; step();
    bif.load = 1'b0;
    vectors++; if (bif.count !== 3'd2 || bif.out_data !== 32'hD5) begin miscompares++; $display("FAIL refill: got count %0d data %h want 2 d5", bif.count, bif.out_data); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b want 0", bif.out_valid); end
    vectors++; if (bif.count !== 3'd0) begin miscompares++; $display("FAIL async_count: got %0d want 0", bif.count); end
    vectors++; if (bif.out_data !== 32'h0) begin miscompares++; $display("FAIL async_data: got %h want 0", bif.out_data); end
    #1 reset = 1'b1;
    bif.bus = 32'hE0; bif.load = 1'b1; step(); bif.load = 1'b0;
    vectors++; if (bif.count !== 3'd1 || bif.out_data !== 32'hE0) begin miscompares++; $display("FAIL post_reset: got count %0d data %h want 1 e0", bif.count, bif.out_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_back_to_back();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
